key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream conditioning stage between the board push-button pins and the memory-mapped key device.
- Synchronizes each raw, asynchronous, bouncing key input into the CLK domain and debounces it with a per-key stability counter.
- Drives the clean, active-high KEY vector that the key device reads and compares for its change flag.
- Also produces a one-cycle per-key change strobe, reserved for a future interrupt path.

Parameters:
- NKEYS, 4, number of independent key inputs.
- DEBOUNCE, 500000, consecutive cycles the synchronized level must differ from the output before the output follows it; must be at least 1 (10 ms at 50 MHz).
- ACTIVE_LOW, 1, 1 means raw pins read 0 when pressed and are inverted so KEY reads 1 when pressed; 0 means no inversion.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- KEY_RAW  input  NKEYS  raw button pins; asynchronous to CLK; may bounce.
- KEY  output  NKEYS  debounced key levels, registered, 1 = pressed.
- KEY_CHG  output  NKEYS  one-cycle strobe per bit on the edge where that KEY bit changes.

Behaviour:
- Clocking: one clock CLK. Reset is synchronous and active-high on RESET. There is no asynchronous clear.
- Each key is fully independent. There is no cross-key interaction.
- Polarity: lvl = KEY_RAW ^ {NKEYS{ACTIVE_LOW}}. The inversion is applied before the synchronizer.
- Synchronizer: two flops per key, s1 <= lvl, then s2 <= s1. Only s2 feeds the debounce logic.
- Per-key state:
  - stable, which drives KEY.
  - cnt, an unsigned counter of width clog2(DEBOUNCE), minimum 1 bit.
- Each rising edge, when RESET is low:
  - If s2 == stable: cnt <= 0 and KEY_CHG <= 0. This discards any glitch.
  - Else if cnt == DEBOUNCE-1: stable <= s2, cnt <= 0, KEY_CHG <= 1.
  - Else: cnt <= cnt+1 and KEY_CHG <= 0.
- Latency:
  - Call the first edge that samples the new raw level edge 1.
  - KEY updates on edge DEBOUNCE+2: 2 synchronizer edges plus DEBOUNCE mismatch edges.
  - KEY_CHG is high for exactly the cycle following that edge.
- Glitch rule:
  - A pulse whose synchronized width is at most DEBOUNCE-1 cycles never changes KEY.
  - Any single cycle with s2 == stable restarts the count from 0.
- Press and release are debounced identically (symmetric).
- cnt never exceeds DEBOUNCE-1 and never wraps.
- DEBOUNCE=1 is legal: KEY follows s2 one edge after the mismatch appears, for a total latency of 3 edges.
- Reset values:
  - s1 = s2 = 0 (released, after polarity), so a held-released pin produces no spurious change after reset.
  - stable = 0, cnt = 0, KEY = 0, KEY_CHG = 0.
- Reset mid-count: all state returns to the reset values on that edge and no strobe is issued. A key held pressed through reset is re-debounced from scratch and reaches KEY = 1 DEBOUNCE+2 edges after RESET falls.
- Reset has priority over every other update in the same cycle.
- Simultaneous events: keys may change on the same edge. Each bit's KEY and KEY_CHG are updated independently in that cycle.
- Outputs are registered only. There is no combinational path from KEY_RAW to KEY or KEY_CHG.

Decomposition:
- No shared package is needed.
- The DEBOUNCE default for the target clock belongs in the project's global constants, alongside the bus-width and base-address constants used by the memory-mapped devices.
- One sub-module is natural: key_debounce_bit, a single key containing its synchronizer, counter, stable flop and strobe.
- key_debounce instantiates NKEYS copies in a generate loop and applies the polarity inversion.

Test Plan:
All scenarios use DEBOUNCE=4, NKEYS=4 and ACTIVE_LOW=1 unless noted.
- Reset/idle: KEY_RAW=4'hF, RESET high for 2 edges, then low for 20 edges -> KEY=4'h0 and KEY_CHG=4'h0 throughout, with no strobe after reset release.
- Clean press: KEY_RAW[0] 1->0 before edge 1 and held -> KEY[0] rises on edge 6, KEY_CHG=4'h1 for exactly one cycle, then KEY_CHG=0. Release gives the symmetric result: KEY[0] falls on edge 6 relative to the release, with one KEY_CHG pulse.
- Bounce: KEY_RAW[1] toggles 0,1,0,1 with 3-cycle pulses, then holds 0 -> KEY[1] changes exactly once, 6 edges after the final settle, and KEY_CHG[1] pulses exactly once.
- Sub-threshold glitch: KEY_RAW[2] low for 3 cycles, then high -> KEY[2] stays 0 and KEY_CHG stays 0.
- Simultaneous and reset mid-count:
  - Keys 0 and 3 pressed on the same edge -> KEY=4'h9 and KEY_CHG=4'h9 on the same cycle.
  - Separately, assert RESET 3 edges into a press, then release with the key still held -> no strobe; KEY[0]=1 arrives 6 edges after RESET falls.
- Parameter corners:
  - DEBOUNCE=1 -> a press reaches KEY on edge 3.
  - ACTIVE_LOW=0 -> raw 0->1 gives KEY=1 with the same latency.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Project-wide constants for the key conditioning path and a counter sizing helper.
package key_debounce_pkg;

    // 10 ms of stability at the 50 MHz system clock.
    localparam int unsigned DEBOUNCE_DEFAULT = 500000;
    localparam int unsigned NKEYS_DEFAULT    = 4;

    // Counter width able to hold DEBOUNCE-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned debounce);
        return (debounce > 1) ? $clog2(debounce) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: two-flop synchronizer, stability counter, debounced level and change strobe.
module key_debounce_bit
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic LVL,
    output logic KEY,
    output logic KEY_CHG
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Synchronize, then let KEY follow s2 only after DEBOUNCE consecutive mismatches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            KEY     <= 1'b0;
            KEY_CHG <= 1'b0;
        end else begin
            s1 <= LVL;
            s2 <= s1;
            if (s2 == KEY) begin
                cnt     <= '0;
                KEY_CHG <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                KEY     <= s2;
                cnt     <= '0;
                KEY_CHG <= 1'b1;
            end else begin
                cnt     <= cnt + CW'(1);
                KEY_CHG <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioning: polarity fix-up and an independent debouncer per key.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NKEYS      = NKEYS_DEFAULT,
    parameter int unsigned DEBOUNCE   = DEBOUNCE_DEFAULT,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [NKEYS-1:0] KEY_RAW,
    output logic [NKEYS-1:0] KEY,
    output logic [NKEYS-1:0] KEY_CHG
);

    localparam logic INV = (ACTIVE_LOW != 0);

    logic [NKEYS-1:0] lvl;

    // Normalize to 1 = pressed ahead of the synchronizers.
    assign lvl = KEY_RAW ^ {NKEYS{INV}};

    // One fully independent debouncer per key.
    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce_bit #(
            .DEBOUNCE(DEBOUNCE)
        ) u_bit (
            .CLK    (CLK),
            .RESET  (RESET),
            .LVL    (lvl[i]),
            .KEY    (KEY[i]),
            .KEY_CHG(KEY_CHG[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: expected strobes are queued by the stimulus and
// checked by per-instance monitors whenever a KEY_CHG strobe appears.
module tb_key_debounce;

    typedef struct {
        int         cyc;
        logic [3:0] key;
        logic [3:0] chg;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] raw_m, raw_d1, raw_a0;
    logic [3:0] key_m, key_d1, key_a0;
    logic [3:0] chg_m, chg_d1, chg_a0;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q_m[$];
    exp_t q_d1[$];
    exp_t q_a0[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    key_debounce #(.NKEYS(4), .DEBOUNCE(4), .ACTIVE_LOW(1)) u_main (
        .CLK(CLK), .RESET(RESET), .KEY_RAW(raw_m), .KEY(key_m), .KEY_CHG(chg_m));
    key_debounce #(.NKEYS(4), .DEBOUNCE(1), .ACTIVE_LOW(1)) u_d1 (
        .CLK(CLK), .RESET(RESET), .KEY_RAW(raw_d1), .KEY(key_d1), .KEY_CHG(chg_d1));
    key_debounce #(.NKEYS(4), .DEBOUNCE(4), .ACTIVE_LOW(0)) u_a0 (
        .CLK(CLK), .RESET(RESET), .KEY_RAW(raw_a0), .KEY(key_a0), .KEY_CHG(chg_a0));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitors: every strobe must match the oldest queued expectation.
    always @(negedge CLK) begin : mon_m
        exp_t e;
        if (chg_m != 4'h0) begin
            if (q_m.size() == 0) chk("main_spurious_chg", int'(chg_m), 0);
            else begin
                e = q_m.pop_front();
                chk("main_chg_cycle", cyc, e.cyc);
                chk("main_key", int'(key_m), int'(e.key));
                chk("main_chg", int'(chg_m), int'(e.chg));
            end
        end
    end

    always @(negedge CLK) begin : mon_d1
        exp_t e;
        if (chg_d1 != 4'h0) begin
            if (q_d1.size() == 0) chk("d1_spurious_chg", int'(chg_d1), 0);
            else begin
                e = q_d1.pop_front();
                chk("d1_chg_cycle", cyc, e.cyc);
                chk("d1_key", int'(key_d1), int'(e.key));
                chk("d1_chg", int'(chg_d1), int'(e.chg));
            end
        end
    end

    always @(negedge CLK) begin : mon_a0
        exp_t e;
        if (chg_a0 != 4'h0) begin
            if (q_a0.size() == 0) chk("al0_spurious_chg", int'(chg_a0), 0);
            else begin
                e = q_a0.pop_front();
                chk("al0_chg_cycle", cyc, e.cyc);
                chk("al0_key", int'(key_a0), int'(e.key));
                chk("al0_chg", int'(chg_a0), int'(e.chg));
            end
        end
    end

    // Stimulus: inputs change on the falling edge; cyc then names the last rising edge.
    initial begin
        RESET  = 1'b1;
        raw_m  = 4'hF;
        raw_d1 = 4'hF;
        raw_a0 = 4'h0;
        wait_n(2);
        RESET = 1'b0;

        // Idle after reset: nothing pressed, no strobes.
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("idle_key", int'(key_m), 0);
            chk("idle_chg", int'(chg_m), 0);
        end

        // Clean press and release of key 0.
        raw_m = 4'hE;
        q_m.push_back('{cyc + 6, 4'h1, 4'h1});
        wait_n(12);
        chk("press_hold_key", int'(key_m), 1);
        raw_m = 4'hF;
        q_m.push_back('{cyc + 6, 4'h0, 4'h1});
        wait_n(12);

        // Key 1 bounces with 3-cycle pulses, then settles pressed.
        for (int i = 0; i < 2; i++) begin
            raw_m = 4'hD;
            wait_n(3);
            raw_m = 4'hF;
            wait_n(3);
        end
        raw_m = 4'hD;
        q_m.push_back('{cyc + 6, 4'h2, 4'h2});
        wait_n(12);
        raw_m = 4'hF;
        q_m.push_back('{cyc + 6, 4'h0, 4'h2});
        wait_n(12);

        // Key 2 glitch shorter than the debounce window.
        raw_m = 4'hB;
        wait_n(3);
        raw_m = 4'hF;
        wait_n(12);
        chk("glitch_key", int'(key_m), 0);

        // Keys 0 and 3 together.
        raw_m = 4'h6;
        q_m.push_back('{cyc + 6, 4'h9, 4'h9});
        wait_n(12);
        raw_m = 4'hF;
        q_m.push_back('{cyc + 6, 4'h0, 4'h9});
        wait_n(12);

        // Reset three edges into a press; key held through and after reset.
        raw_m = 4'hE;
        wait_n(3);
        RESET = 1'b1;
        wait_n(2);
        RESET = 1'b0;
        chk("rst_mid_key", int'(key_m), 0);
        chk("rst_mid_chg", int'(chg_m), 0);
        q_m.push_back('{cyc + 6, 4'h1, 4'h1});
        wait_n(12);
        raw_m = 4'hF;
        q_m.push_back('{cyc + 6, 4'h0, 4'h1});
        wait_n(12);

        // DEBOUNCE=1: press and release reach KEY on edge 3.
        raw_d1 = 4'hE;
        q_d1.push_back('{cyc + 3, 4'h1, 4'h1});
        wait_n(8);
        raw_d1 = 4'hF;
        q_d1.push_back('{cyc + 3, 4'h0, 4'h1});
        wait_n(8);

        // Active-high pins: raw 0->1 is a press.
        raw_a0 = 4'h1;
        q_a0.push_back('{cyc + 6, 4'h1, 4'h1});
        wait_n(12);
        raw_a0 = 4'h0;
        q_a0.push_back('{cyc + 6, 4'h0, 4'h1});
        wait_n(12);

        // Every expected strobe must have been seen.
        chk("main_missing_chg", q_m.size(), 0);
        chk("d1_missing_chg", q_d1.size(), 0);
        chk("al0_missing_chg", q_a0.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
